aha_tlx_train_checker: RTL and testbench



---
 rtl/aha_tlx_train_checker.sv | 169 ++++++++++++++++
 tb/tb_aha_tlx_train_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aha_tlx_train_checker.sv
// aha_tlx_train_checker
// Receive-side training checker for one TLX reverse lane. It searches the
// sampled lane bit stream for the repeating training word at any rotation and
// verifies it over a run of clean bits before declaring lock. While locked it
// counts bit errors and drops lock after a burst of consecutive errors.

module aha_tlx_train_checker #(
  parameter int                       PATTERN_WIDTH  = 32,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN        = PATTERN_WIDTH'(32'h0F3A_96C5),
  parameter int                       LOCK_COUNT     = 64,
  parameter int                       MAX_CONSEC_ERR = 4,
  parameter int                       ERR_CNT_WIDTH  = 16
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               ENABLE,
  input  logic                               DATA_IN,
  input  logic                               CLEAR_ERR,
  output logic                               SEARCHING,
  output logic                               LOCKED,
  output logic                               LOCK_LOST,
  output logic [$clog2(PATTERN_WIDTH)-1:0]   BIT_OFFSET,
  output logic [ERR_CNT_WIDTH-1:0]           ERR_COUNT
);

  localparam int OFF_W  = $clog2(PATTERN_WIDTH);
  localparam int FCNT_W = $clog2(PATTERN_WIDTH + 1);
  localparam int VCNT_W = $clog2(LOCK_COUNT + 1);
  localparam int ECNT_W = $clog2(MAX_CONSEC_ERR + 1);

  // Two copies back to back let every rotation be taken as a plain slice.
  localparam logic [2*PATTERN_WIDTH-1:0] PATTERN_TWICE = {PATTERN, PATTERN};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t                     state, state_nxt;
  logic [PATTERN_WIDTH-1:0]   sr;
  logic [FCNT_W-1:0]          fcnt, fcnt_nxt;
  logic [VCNT_W-1:0]          vcnt, vcnt_nxt;
  logic [ECNT_W-1:0]          ecnt, ecnt_nxt;
  logic [OFF_W-1:0]           p, p_nxt, p_inc;
  logic [OFF_W-1:0]           offset_nxt;
  logic [ERR_CNT_WIDTH-1:0]   err_nxt;
  logic                       lost_nxt;
  logic                       bit_ok;
  logic                       hit;
  logic [OFF_W-1:0]           hit_r;

  // Phase pointer advance, wrapping from W-1 back to 0.
  function automatic logic [OFF_W-1:0] wrap_inc(input logic [OFF_W-1:0] v);
    return (v == OFF_W'(PATTERN_WIDTH - 1)) ? '0 : v + 1'b1;
  endfunction

  // Compare all rotations in parallel; scanning downward leaves the lowest match.
  always_comb begin
    hit   = 1'b0;
    hit_r = '0;
    for (int r = PATTERN_WIDTH - 1; r >= 0; r--) begin
      if (sr == PATTERN_TWICE[r +: PATTERN_WIDTH]) begin
        hit   = 1'b1;
        hit_r = OFF_W'(r);
      end
    end
  end

  // Next-state and counter update logic for the search/verify/lock FSM.
  always_comb begin
    state_nxt  = state;
    fcnt_nxt   = fcnt;
    vcnt_nxt   = vcnt;
    ecnt_nxt   = ecnt;
    p_nxt      = p;
    offset_nxt = BIT_OFFSET;
    err_nxt    = ERR_COUNT;
    lost_nxt   = 1'b0;
    p_inc      = wrap_inc(p);
    bit_ok     = (DATA_IN == PATTERN[p]);

    if (!ENABLE) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_SEARCH;
          fcnt_nxt  = '0;
        end
        ST_SEARCH: begin
          if (fcnt == FCNT_W'(PATTERN_WIDTH)) begin
            if (hit) begin
              state_nxt  = ST_VERIFY;
              offset_nxt = hit_r;
              p_nxt      = wrap_inc(hit_r);
              vcnt_nxt   = '0;
            end
          end else begin
            fcnt_nxt = fcnt + 1'b1;
          end
        end
        ST_VERIFY: begin
          p_nxt = p_inc;
          if (bit_ok) begin
            vcnt_nxt = vcnt + 1'b1;
            if (vcnt == VCNT_W'(LOCK_COUNT - 1)) begin
              state_nxt = ST_LOCKED;
              ecnt_nxt  = '0;
            end
          end else begin
            state_nxt = ST_SEARCH;
            fcnt_nxt  = '0;
          end
        end
        ST_LOCKED: begin
          p_nxt = p_inc;
          if (bit_ok) begin
            ecnt_nxt = '0;
          end else begin
            err_nxt  = (ERR_COUNT == '1) ? ERR_COUNT : ERR_COUNT + 1'b1;
            ecnt_nxt = ecnt + 1'b1;
            if (ecnt == ECNT_W'(MAX_CONSEC_ERR - 1)) begin
              state_nxt = ST_SEARCH;
              fcnt_nxt  = '0;
              lost_nxt  = 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    if (CLEAR_ERR) begin
      err_nxt = '0;
    end
  end

  // State, shift register and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      sr         <= '0;
      fcnt       <= '0;
      vcnt       <= '0;
      ecnt       <= '0;
      p          <= '0;
      BIT_OFFSET <= '0;
      ERR_COUNT  <= '0;
      SEARCHING  <= 1'b0;
      LOCKED     <= 1'b0;
      LOCK_LOST  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= {DATA_IN, sr[PATTERN_WIDTH-1:1]};
      fcnt       <= fcnt_nxt;
      vcnt       <= vcnt_nxt;
      ecnt       <= ecnt_nxt;
      p          <= p_nxt;
      BIT_OFFSET <= offset_nxt;
      ERR_COUNT  <= err_nxt;
      SEARCHING  <= (state_nxt == ST_SEARCH) || (state_nxt == ST_VERIFY);
      LOCKED     <= (state_nxt == ST_LOCKED);
      LOCK_LOST  <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_aha_tlx_train_checker.sv
// Directed self-checking bench for aha_tlx_train_checker. A second instance
// with a 4-bit error counter shares the stimulus to exercise saturation.

module tb_aha_tlx_train_checker;

  localparam int          W   = 32;
  localparam logic [31:0] PAT = 32'h0F3A_96C5;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        DATA_IN;
  logic        CLEAR_ERR;

  logic        searching, locked, lock_lost;
  logic [4:0]  bit_offset;
  logic [15:0] err_count;

  logic        searching4, locked4, lock_lost4;
  logic [4:0]  bit_offset4;
  logic [3:0]  err_count4;

  int checks = 0;
  int errors = 0;
  int tx_idx = 0;
  int lost_cycles = 0;
  int overlap = 0;
  int exp_off = 0;

  aha_tlx_train_checker dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .DATA_IN    (DATA_IN),
    .CLEAR_ERR  (CLEAR_ERR),
    .SEARCHING  (searching),
    .LOCKED     (locked),
    .LOCK_LOST  (lock_lost),
    .BIT_OFFSET (bit_offset),
    .ERR_COUNT  (err_count)
  );

  aha_tlx_train_checker #(.ERR_CNT_WIDTH(4)) dut4 (
    .CLK        (CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .DATA_IN    (DATA_IN),
    .CLEAR_ERR  (CLEAR_ERR),
    .SEARCHING  (searching4),
    .LOCKED     (locked4),
    .LOCK_LOST  (lock_lost4),
    .BIT_OFFSET (bit_offset4),
    .ERR_COUNT  (err_count4)
  );

  // Free-running sample clock.
  always #5 CLK = ~CLK;

  // Count a comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one bit, let one edge pass, then sample away from the edge.
  task automatic applyStimulus(input logic d, input logic en, input logic clr);
    DATA_IN   = d;
    ENABLE    = en;
    CLEAR_ERR = clr;
    @(posedge CLK);
    #1;
    if (lock_lost) lost_cycles++;
    if ((searching && locked) || (searching4 && locked4)) overlap++;
  endtask

  // Send n consecutive correct training bits continuing from tx_idx.
  task automatic sendPattern(input int n);
    logic [4:0] idx;
    for (int i = 0; i < n; i++) begin
      idx = 5'(tx_idx % W);
      applyStimulus(PAT[idx], 1'b1, 1'b0);
      tx_idx++;
    end
  endtask

  // Send one inverted training bit, optionally with CLEAR_ERR on the same edge.
  task automatic sendFlip(input logic clr);
    logic [4:0] idx;
    idx = 5'(tx_idx % W);
    applyStimulus(~PAT[idx], 1'b1, clr);
    tx_idx++;
  endtask

  initial begin
    RESET = 1'b1;
    ENABLE = 1'b0;
    DATA_IN = 1'b0;
    CLEAR_ERR = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rstSearching", 32'(searching), 0);
    checkOutput("rstLocked", 32'(locked), 0);
    checkOutput("rstLockLost", 32'(lock_lost), 0);
    checkOutput("rstOffset", 32'(bit_offset), 0);
    checkOutput("rstErr", 32'(err_count), 0);
    RESET = 1'b0;

    // Clean lock from PATTERN[0]
    applyStimulus(1'b0, 1'b1, 1'b0);
    tx_idx = 0;
    checkOutput("searchAfterEnable", 32'(searching), 1);
    sendPattern(96);
    checkOutput("cleanNotLocked96", 32'(locked), 0);
    sendPattern(1);
    checkOutput("cleanLocked97", 32'(locked), 1);
    checkOutput("cleanNotSearching", 32'(searching), 0);
    checkOutput("cleanOffset", 32'(bit_offset), 0);
    checkOutput("cleanErr", 32'(err_count), 0);

    // Isolated errors while locked
    lost_cycles = 0;
    for (int k = 0; k < 3; k++) begin
      sendPattern(10);
      sendFlip(1'b0);
    end
    sendPattern(5);
    checkOutput("isoErr", 32'(err_count), 3);
    checkOutput("isoLocked", 32'(locked), 1);
    checkOutput("isoNoLost", 32'(lost_cycles), 0);

    // Burst of four errors drops lock
    repeat (3) sendFlip(1'b0);
    checkOutput("burst3Locked", 32'(locked), 1);
    checkOutput("burst3Err", 32'(err_count), 6);
    checkOutput("burst3NoLost", 32'(lock_lost), 0);
    sendFlip(1'b0);
    checkOutput("burst4Locked", 32'(locked), 0);
    checkOutput("burst4Lost", 32'(lock_lost), 1);
    checkOutput("burst4Searching", 32'(searching), 1);
    checkOutput("burst4Err", 32'(err_count), 7);
    exp_off = tx_idx % W;
    sendPattern(1);
    checkOutput("lostPulseEnds", 32'(lock_lost), 0);
    sendPattern(95);
    checkOutput("relockNotYet", 32'(locked), 0);
    sendPattern(1);
    checkOutput("relockLocked", 32'(locked), 1);
    checkOutput("relockOffset", 32'(bit_offset), 32'(exp_off));

    // Disable from LOCKED, then align at PATTERN[5]
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("disLocked", 32'(locked), 0);
    checkOutput("disSearching", 32'(searching), 0);
    checkOutput("disNoLost", 32'(lock_lost), 0);
    checkOutput("disErrKept", 32'(err_count), 7);
    checkOutput("disOffsetKept", 32'(bit_offset), 32'(exp_off));
    applyStimulus(1'b0, 1'b1, 1'b0);
    tx_idx = 5;
    sendPattern(96);
    checkOutput("off5NotYet", 32'(locked), 0);
    sendPattern(1);
    checkOutput("off5Locked", 32'(locked), 1);
    checkOutput("off5Offset", 32'(bit_offset), 5);
    checkOutput("off5Err", 32'(err_count), 7);

    // VERIFY failure ten bits into verification
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tx_idx = 0;
    sendPattern(42);
    checkOutput("verifySearching", 32'(searching), 1);
    sendFlip(1'b0);
    checkOutput("vfailSearching", 32'(searching), 1);
    checkOutput("vfailLocked", 32'(locked), 0);
    checkOutput("vfailErr", 32'(err_count), 7);
    exp_off = tx_idx % W;
    sendPattern(96);
    checkOutput("vfailNotYet", 32'(locked), 0);
    sendPattern(1);
    checkOutput("vfailRelock", 32'(locked), 1);
    checkOutput("vfailOffset", 32'(bit_offset), 32'(exp_off));

    // CLEAR_ERR on the same edge as an error
    sendFlip(1'b1);
    checkOutput("clrErr", 32'(err_count), 0);
    checkOutput("clrErr4", 32'(err_count4), 0);
    sendFlip(1'b0);
    checkOutput("afterClrErr", 32'(err_count), 1);
    sendPattern(1);

    // Twenty separated errors saturate the 4-bit counter
    for (int k = 0; k < 20; k++) begin
      sendFlip(1'b0);
      sendPattern(1);
    end
    checkOutput("satErr4", 32'(err_count4), 15);
    checkOutput("satErr16", 32'(err_count), 21);
    checkOutput("satLocked4", 32'(locked4), 1);
    checkOutput("satLocked", 32'(locked), 1);

    // Drop ENABLE mid-VERIFY, then relock at offset 7
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tx_idx = 7;
    sendPattern(40);
    checkOutput("midVerifySearching", 32'(searching), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midVerifyIdleS", 32'(searching), 0);
    checkOutput("midVerifyIdleL", 32'(locked), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tx_idx = 7;
    sendPattern(96);
    checkOutput("off7NotYet", 32'(locked), 0);
    sendPattern(1);
    checkOutput("off7Locked", 32'(locked), 1);
    checkOutput("off7Offset", 32'(bit_offset), 7);
    checkOutput("off7ErrKept", 32'(err_count), 21);

    // RESET while locked with ENABLE held high
    RESET = 1'b1;
    sendPattern(1);
    RESET = 1'b0;
    checkOutput("midRstSearching", 32'(searching), 0);
    checkOutput("midRstLocked", 32'(locked), 0);
    checkOutput("midRstLost", 32'(lock_lost), 0);
    checkOutput("midRstOffset", 32'(bit_offset), 0);
    checkOutput("midRstErr", 32'(err_count), 0);
    checkOutput("midRstErr4", 32'(err_count4), 0);
    sendPattern(1);
    checkOutput("postRstSearch", 32'(searching), 1);

    checkOutput("neverBothSearchLock", 32'(overlap), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
